pair_transition_monitor: RTL
============================

// Module: pair_transition_monitor
// PURPOSE
// Capture-side counterpart of the correlation stimulus sequence. Receives the masked-gate output
// sampled once per phase of each (i, j) vector pair, counts output bit transitions from the BEGIN
// phase (vector i) to the END phase (vector j), accumulates the count over all j for each i, and
// streams one result per i. It sits after the gate-level DUT in the correlation flow.
// PARAMETERS
// IN_W     5  input-vector width; 2**IN_W values of i and of j
// OUT_W    1  DUT output width sampled per phase
// COUNT_W  8  per-i accumulator/result width; saturates at 2**COUNT_W-1
// PORTS
// clk           in   1        rising-edge clock
// rst_n         in   1        asynchronous active-low reset
// start         in   1        one-cycle pulse; starts a sweep from IDLE or DONE, ignored otherwise
// smp_valid     in   1        y holds one phase sample this cycle
// y             in   OUT_W    DUT output sample
// res_valid     out  1        result available
// res_ready     in   1        consumer accepts result
// res_idx       out  IN_W     i of the current result
// res_count     out  COUNT_W  sum over j of popcount(y_i ^ y_j)
// busy          out  1        high in FIRST, SECOND, EMIT
// done          out  1        high in DONE
// overrun       out  1        sticky; a sample was dropped
// BEHAVIOUR
// - Reset: state=IDLE; i=j=0; acc=0; every output 0, including res_idx, res_count and overrun.
// - States: IDLE -start-> FIRST -smp_valid-> SECOND -smp_valid-> FIRST or EMIT.
//   EMIT -res_ready-> FIRST, or DONE after i=2**IN_W-1. DONE -start-> FIRST.
// - FIRST: register y as y_first (vector i, BEGIN phase).
// - SECOND: on a sample, acc += popcount(y_first ^ y), saturating at 2**COUNT_W-1. Then:
//   j < 2**IN_W-1: j++, go to FIRST.
//   j = 2**IN_W-1: j=0, go to EMIT.
// - EMIT: res_valid=1. res_idx=i and res_count=acc are stable until accepted.
//   Transfer occurs when res_valid & res_ready on a clock edge. On transfer: acc=0, i++ (IN_W wrap).
//   res_valid drops the cycle after transfer. res_ready=1 on entry gives a one-cycle EMIT.
// - Samples while in EMIT, IDLE or DONE are dropped. In EMIT and DONE a dropped sample sets overrun.
//   In IDLE, samples are ignored silently.
// - Latency: the last SECOND sample of i gives res_valid on the next cycle.
// - start while busy is ignored. start in DONE clears overrun, i, j and acc.
// - Asserting rst_n low at any point, mid-pair included, aborts immediately to reset values.
//   A partial pair is discarded.
// - Popcount is OUT_W wide. Accumulation is zero-extended to COUNT_W before the saturating add.
// CONFIGURATION
// CORR_PAIR_TRACE_EN defined adds these outputs:
//   pair_valid (1), pair_i (IN_W), pair_j (IN_W), pair_tog ($clog2(OUT_W+1)).
//   pair_valid pulses one cycle after each accepted SECOND sample.
//   pair_i/pair_j/pair_tog hold that pair's indices and its popcount.
//   All trace outputs reset to 0.
// CORR_PAIR_TRACE_EN undefined: these ports and their logic do not exist. Other behaviour is identical.
// TESTING
// 1 Reset then idle: after rst_n 0->1, all outputs are 0. smp_valid pulses in IDLE leave overrun=0.
// 2 Constant y=0 for a full sweep (2048 samples), res_ready=1:
//   32 results, res_idx 0..31, every res_count=0, then done=1.
// 3 OUT_W=1, y=1 in FIRST and y=0 in SECOND for every pair: every res_count=32.
//   With COUNT_W=5: res_count saturates at 31.
// 4 res_ready=0 for 10 cycles in EMIT with 3 samples sent:
//   res_idx/res_count are held, overrun=1, and the next i starts only after res_ready=1.
// 5 rst_n low after 17 samples (mid-pair):
//   all outputs 0. A fresh start then yields res_idx=0 with count only from post-reset samples.
// 6 With CORR_PAIR_TRACE_EN, OUT_W=2, y 2'b01 then 2'b10 for pair (0,3):
//   pair_valid pulse with pair_i=0, pair_j=3, pair_tog=2.

Source files
------------

// File: rtl/pair_transition_monitor_if.sv
// Sample-in / result-out channel between the correlation capture flow and
// pair_transition_monitor. The master drives the samples and consumes the
// results. The slave is the monitor.
interface pair_transition_monitor_if #(
    parameter int IN_W    = 5,
    parameter int OUT_W   = 1,
    parameter int COUNT_W = 8
);
    logic               smp_valid;
    logic [OUT_W-1:0]   y;
    logic               res_valid;
    logic               res_ready;
    logic [IN_W-1:0]    res_idx;
    logic [COUNT_W-1:0] res_count;

    modport master (
        output smp_valid, y, res_ready,
        input  res_valid, res_idx, res_count
    );

    modport slave (
        input  smp_valid, y, res_ready,
        output res_valid, res_idx, res_count
    );
endinterface

// File: rtl/pair_transition_monitor.sv
// pair_transition_monitor: for every vector i, sums the output bit toggles
// between the BEGIN sample (i) and the END sample (j) over all j. It then
// streams one saturating count per i.
// Optional build macro CORR_PAIR_TRACE_EN adds per-pair trace outputs.
module pair_transition_monitor #(
    parameter int IN_W    = 5,
    parameter int OUT_W   = 1,
    parameter int COUNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    pair_transition_monitor_if.slave      bus,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun
`ifdef CORR_PAIR_TRACE_EN
    ,
    output logic                          pair_valid,
    output logic [IN_W-1:0]               pair_i,
    output logic [IN_W-1:0]               pair_j,
    output logic [$clog2(OUT_W+1)-1:0]    pair_tog
`endif
);
    localparam int                 PC_W = $clog2(OUT_W + 1);
    localparam logic [IN_W-1:0]    LAST = '1;
    localparam logic [COUNT_W-1:0] SAT  = '1;

    typedef enum logic [2:0] {S_IDLE, S_FIRST, S_SECOND, S_EMIT, S_DONE} state_t;

    state_t             state;
    logic [OUT_W-1:0]   y_first;
    logic [IN_W-1:0]    i_q;
    logic [IN_W-1:0]    j_q;
    logic [COUNT_W-1:0] acc;
    logic               res_valid_q;
    logic [PC_W-1:0]    pc;
    logic [COUNT_W:0]   sum;

    // The result is presented straight from the live i and accumulator.
    // Neither register changes while EMIT waits for res_ready.
    assign bus.res_idx   = i_q;
    assign bus.res_count = acc;
    assign bus.res_valid = res_valid_q;

    // Toggle count of the current pair and the accumulator sum, one bit wider.
    // The extra bit catches overflow.
    always_comb begin
        pc = '0;
        for (int b = 0; b < OUT_W; b++)
            pc = pc + PC_W'(y_first[b] ^ bus.y[b]);
        sum = {1'b0, acc} + (COUNT_W + 1)'(pc);
    end

    // Sweep FSM. Every output is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            y_first     <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc         <= '0;
            res_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
`ifdef CORR_PAIR_TRACE_EN
            pair_valid  <= 1'b0;
            pair_i      <= '0;
            pair_j      <= '0;
            pair_tog    <= '0;
`endif
        end else begin
`ifdef CORR_PAIR_TRACE_EN
            pair_valid <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // Samples here are ignored, and they do not set overrun.
                    if (start) begin
                        state <= S_FIRST;
                        busy  <= 1'b1;
                    end
                end
                S_FIRST: begin
                    if (bus.smp_valid) begin
                        y_first <= bus.y;
                        state   <= S_SECOND;
                    end
                end
                S_SECOND: begin
                    if (bus.smp_valid) begin
                        acc <= sum[COUNT_W] ? SAT : sum[COUNT_W-1:0];
`ifdef CORR_PAIR_TRACE_EN
                        pair_valid <= 1'b1;
                        pair_i     <= i_q;
                        pair_j     <= j_q;
                        pair_tog   <= pc;
`endif
                        if (j_q == LAST) begin
                            j_q         <= '0;
                            state       <= S_EMIT;
                            res_valid_q <= 1'b1;
                        end else begin
                            j_q   <= j_q + 1'b1;
                            state <= S_FIRST;
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.smp_valid)
                        overrun <= 1'b1;
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        acc         <= '0;
                        i_q         <= i_q + 1'b1;
                        if (i_q == LAST) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FIRST;
                        end
                    end
                end
                S_DONE: begin
                    // A restart clears the sticky overrun flag together with the sweep indices.
                    if (start) begin
                        state   <= S_FIRST;
                        overrun <= 1'b0;
                        i_q     <= '0;
                        j_q     <= '0;
                        acc     <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else if (bus.smp_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
